// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a registered read, a clear sweep after reset and ready/valid handshaking.
// Optional per-word even parity with error injection is enabled by defining RAM_PARITY_EN.
module sync_ram #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  notChipEnable,
    input  logic                  notWriteEnable,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
`ifdef RAM_PARITY_EN
    input  logic                  injectParityErr,
    output logic                  parityError,
`endif
    output logic                  ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef RAM_PARITY_EN
    localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
    localparam int WORD_WIDTH = DATA_WIDTH;
`endif

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    state_t                stateReg;
    state_t                stateNext;
    logic [ADDR_WIDTH:0]   clearAddrReg;
    logic [ADDR_WIDTH:0]   clearAddrNext;
    logic                  readyReg;
    logic                  sweepWrite;

    logic                  accessOk;
    logic                  hostWrite;
    logic                  hostRead;
    logic                  wrEn;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [DATA_WIDTH-1:0] wrData;
    logic [WORD_WIDTH-1:0] wrWord;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] dataOutReg;
    logic                  dataValidReg;

    // Sweep sequencer: the extra clearAddr bit flags that the last word has been written.
    always_comb begin
        stateNext     = stateReg;
        clearAddrNext = clearAddrReg;
        sweepWrite    = 1'b0;
        case (stateReg)
            CLEAR: begin
                sweepWrite    = 1'b1;
                clearAddrNext = clearAddrReg + 1'b1;
                if (clearAddrNext[ADDR_WIDTH]) begin
                    stateNext = IDLE;
                end
            end
            IDLE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= RESET_STATE;
            clearAddrReg <= '0;
            readyReg     <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            clearAddrReg <= clearAddrNext;
            readyReg     <= (stateNext == IDLE);
        end
    end

    // Reset is folded in combinationally so nothing is stored while it is held.
    assign accessOk  = readyReg && !reset && !notChipEnable;
    assign hostWrite = accessOk && !notWriteEnable;
    assign hostRead  = accessOk && notWriteEnable;

    assign wrEn   = (sweepWrite && !reset) || hostWrite;
    assign wrAddr = sweepWrite ? clearAddrReg[ADDR_WIDTH-1:0] : address;
    assign wrData = sweepWrite ? CLEAR_VALUE : dataIn;

`ifdef RAM_PARITY_EN
    assign wrWord = {(^wrData) ^ (hostWrite & injectParityErr), wrData};
`else
    assign wrWord = wrData;
`endif

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrWord;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dataOutReg   <= '0;
            dataValidReg <= 1'b0;
        end else begin
            dataValidReg <= hostRead;
            if (hostRead) begin
                dataOutReg <= mem[address][DATA_WIDTH-1:0];
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic parityErrorReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            parityErrorReg <= 1'b0;
        end else if (hostRead) begin
            parityErrorReg <= (^mem[address][DATA_WIDTH-1:0]) != mem[address][DATA_WIDTH];
        end else begin
            parityErrorReg <= 1'b0;
        end
    end

    assign parityError = parityErrorReg;
`endif

    assign dataOut   = dataOutReg;
    assign dataValid = dataValidReg;
    assign ready     = readyReg;

endmodule

// File: tb/tb_sync_ram.sv
// Scoreboard bench for sync_ram (16 words, sweep value 4'hA); parity cases run when RAM_PARITY_EN is defined.
module tb_sync_ram;

    localparam int DW = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic          notChipEnable;
    logic          notWriteEnable;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic          ready;
`ifdef RAM_PARITY_EN
    logic          injectParityErr;
    logic          parityError;
`endif

    always #5 clk = ~clk;

    sync_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CLEAR_ON_RESET(1),
        .CLEAR_VALUE(4'hA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .notChipEnable(notChipEnable),
        .notWriteEnable(notWriteEnable),
        .dataIn(dataIn),
        .dataOut(dataOut),
        .dataValid(dataValid),
`ifdef RAM_PARITY_EN
        .injectParityErr(injectParityErr),
        .parityError(parityError),
`endif
        .ready(ready)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every dataValid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (dataValid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got dataValid=1 dataOut=%0h expected no read result", dataOut);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check("read_data", {28'd0, dataOut}, {28'd0, e.data});
`ifdef RAM_PARITY_EN
                check("parity_flag", {31'd0, parityError}, {31'd0, e.perr});
`endif
            end
        end
    end

    task automatic setIdle();
        notChipEnable  = 1'b1;
        notWriteEnable = 1'b1;
`ifdef RAM_PARITY_EN
        injectParityErr = 1'b0;
`endif
    endtask

    task automatic idleCycle();
        setIdle();
        @(negedge clk);
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj);
        address        = a;
        dataIn         = d;
        notChipEnable  = 1'b0;
        notWriteEnable = 1'b0;
`ifdef RAM_PARITY_EN
        injectParityErr = inj;
`else
        if (inj) $display("note: parity injection requested without parity support");
`endif
        @(negedge clk);
    endtask

    task automatic doRead(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic p);
        exp_t e;
        address        = a;
        notChipEnable  = 1'b0;
        notWriteEnable = 1'b1;
`ifdef RAM_PARITY_EN
        injectParityErr = 1'b0;
`endif
        e.data = d;
        e.perr = p;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    // Releases reset and counts negedges with ready=0; optionally attempts a write mid-sweep.
    task automatic waitSweep(input int writeAt, output int cnt);
        cnt   = 0;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ready === 1'b1) break;
            if (cnt == writeAt) begin
                address        = 4'd15;
                dataIn         = 4'h7;
                notChipEnable  = 1'b0;
                notWriteEnable = 1'b0;
            end else begin
                setIdle();
            end
            cnt++;
            @(negedge clk);
        end
        setIdle();
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: ready never rose, got %0d cycles, required 16", cnt);
        end
    endtask

    initial begin
        int cnt;
        reset   = 1'b1;
        address = '0;
        dataIn  = '0;
        setIdle();
        repeat (2) @(negedge clk);

        // Reset state and first sweep
        check("reset_dataOut", {28'd0, dataOut}, 32'h0);
        check("reset_dataValid", {31'd0, dataValid}, 32'h0);
        check("reset_ready", {31'd0, ready}, 32'h0);
        waitSweep(-1, cnt);
        check("sweep_cycles", cnt, 32'd16);

        // Whole array reads back the clear value, back to back
        for (int a = 0; a < 16; a++) doRead(a[AW-1:0], 4'hA, 1'b0);
        idleCycle();
        check("idle_no_valid", {31'd0, dataValid}, 32'h0);

        // Write then read the same address; idle holds the data
        doWrite(4'd3, 4'h5, 1'b0);
        check("write_no_valid", {31'd0, dataValid}, 32'h0);
        doRead(4'd3, 4'h5, 1'b0);
        idleCycle();
        check("idle_valid_low", {31'd0, dataValid}, 32'h0);
        check("idle_data_held", {28'd0, dataOut}, 32'h5);

        // Three consecutive reads keep dataValid high
        doWrite(4'd0, 4'h1, 1'b0);
        doWrite(4'd1, 4'h2, 1'b0);
        doWrite(4'd2, 4'h3, 1'b0);
        doRead(4'd0, 4'h1, 1'b0);
        check("b2b_valid0", {31'd0, dataValid}, 32'h1);
        doRead(4'd1, 4'h2, 1'b0);
        check("b2b_valid1", {31'd0, dataValid}, 32'h1);
        doRead(4'd2, 4'h3, 1'b0);
        check("b2b_valid2", {31'd0, dataValid}, 32'h1);
        idleCycle();

`ifdef RAM_PARITY_EN
        doWrite(4'd9, 4'h6, 1'b1);
        doRead(4'd9, 4'h6, 1'b1);
        doRead(4'd3, 4'h5, 1'b0);
        idleCycle();
        check("parity_low_idle", {31'd0, parityError}, 32'h0);
`endif

        // Read issued together with reset is cancelled
        address        = 4'd3;
        notChipEnable  = 1'b0;
        notWriteEnable = 1'b1;
        reset          = 1'b1;
        @(negedge clk);
        check("reset_read_valid", {31'd0, dataValid}, 32'h0);
        check("reset_read_data", {28'd0, dataOut}, 32'h0);
        setIdle();
        @(negedge clk);

        // Write attempted during the sweep is ignored
        waitSweep(5, cnt);
        check("sweep2_cycles", cnt, 32'd16);
        doRead(4'd15, 4'hA, 1'b0);
        doRead(4'd3, 4'hA, 1'b0);
        idleCycle();

        // Reset in the middle of a sweep restarts it from address 0
        doWrite(4'd5, 4'h3, 1'b0);
        doWrite(4'd15, 4'h1, 1'b0);
        reset = 1'b1;
        setIdle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_sweep_ready", {31'd0, ready}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        waitSweep(-1, cnt);
        check("sweep3_cycles", cnt, 32'd16);
        doRead(4'd5, 4'hA, 1'b0);
        doRead(4'd15, 4'hA, 1'b0);
        repeat (3) idleCycle();

        check("scoreboard_drained", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
